// File: rtl/mii_rx_framer.sv
`default_nettype none
// ============================================================================
// Module   : mii_rx_framer
// Purpose  : Receive-side MII framer for one PHY port. Strips preamble/SFD,
//            packs nibbles (low nibble first) into bytes and writes each frame
//            into the per-port frame FIFO. The delimiter flag is set on the
//            last byte of the frame (FCS included). Handles FIFO space checks,
//            oversize truncation, receive errors and keeps saturating stats.
//            Runs entirely in the MII RX_CLK domain.
// Ports    : clk, arst_n            - RX clock, async active-low reset
//            mii_rxd/_rx_dv/_rx_er  - MII receive interface
//            fifo_din/_del/_wren    - byte, delimiter flag, write enable
//            fifo_full/_afull       - FIFO full / less than MAX_LEN free
//            frame_done/frame_drop  - 1-cycle event pulses
//            stat_frame_cnt/_drop_cnt, stat_ovf - statistics
// Revision : 1.0 - initial release
// ============================================================================
module mii_rx_framer #(
  parameter int MAX_LEN = 1522,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [3:0]       mii_rxd,
  input  logic             mii_rx_dv,
  input  logic             mii_rx_er,
  output logic [7:0]       fifo_din,
  output logic             fifo_del,
  output logic             fifo_wren,
  input  logic             fifo_full,
  input  logic             fifo_afull,
  output logic             frame_done,
  output logic             frame_drop,
  output logic [CNT_W-1:0] stat_frame_cnt,
  output logic [CNT_W-1:0] stat_drop_cnt,
  output logic             stat_ovf
);

  localparam int                 c_LEN_W   = $clog2(MAX_LEN + 1);
  localparam logic [c_LEN_W-1:0] c_MAX_LEN = c_LEN_W'(MAX_LEN);
  localparam logic [3:0]         c_PRE_NIB = 4'h5;
  localparam logic [3:0]         c_SFD_NIB = 4'hD;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               r_nib_phase;
  logic [3:0]         r_low;
  logic [7:0]         r_hold;
  logic               r_hold_valid;
  logic [c_LEN_W-1:0] r_byte_cnt;

  // Decisions for the current cycle; registered into the outputs below.
  logic w_wr;
  logic w_del;
  logic w_done;
  logic w_drop;
  logic w_byte_done;
  logic w_at_max;
  logic w_wr_ok;

  assign w_at_max = (r_byte_cnt == c_MAX_LEN);
  assign w_wr_ok  = w_wr & ~fifo_full;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (mii_rx_dv) begin
          w_state_nxt = (mii_rxd == c_PRE_NIB) ? S_PRE : S_DROP;
        end
      end
      S_PRE: begin
        if (!mii_rx_dv)                                w_state_nxt = S_IDLE;
        else if (mii_rx_er)                            w_state_nxt = S_DROP;
        else if (mii_rxd == c_PRE_NIB)                 w_state_nxt = S_PRE;
        else if (mii_rxd == c_SFD_NIB && !fifo_afull)  w_state_nxt = S_DATA;
        else                                           w_state_nxt = S_DROP;
      end
      S_DATA: begin
        if (!mii_rx_dv)                    w_state_nxt = S_IDLE;
        else if (mii_rx_er)                w_state_nxt = S_DROP;
        else if (r_nib_phase && w_at_max)  w_state_nxt = S_DROP;
        else                               w_state_nxt = S_DATA;
      end
      S_DROP: begin
        if (!mii_rx_dv) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / action decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_wr        = 1'b0;
    w_del       = 1'b0;
    w_done      = 1'b0;
    w_drop      = 1'b0;
    w_byte_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Carrier without a preamble nibble: the whole frame is discarded.
        if (mii_rx_dv && mii_rxd != c_PRE_NIB) w_drop = 1'b1;
      end
      S_PRE: begin
        // Any exit other than into S_DATA abandons the frame.
        if (w_state_nxt == S_DROP || w_state_nxt == S_IDLE) w_drop = 1'b1;
      end
      S_DATA: begin
        if (!mii_rx_dv) begin
          // End of frame; a dangling dribble nibble in r_low is simply ignored.
          if (r_hold_valid) begin
            w_wr   = 1'b1;
            w_del  = 1'b1;
            w_done = 1'b1;
          end else begin
            w_drop = 1'b1;
          end
        end else if (mii_rx_er) begin
          // Close the frame early; the decoder will reject it on FCS.
          if (r_hold_valid) begin
            w_wr   = 1'b1;
            w_del  = 1'b1;
            w_done = 1'b1;
          end
          w_drop = 1'b1;
        end else if (r_nib_phase) begin
          if (w_at_max) begin
            // Oversize: the held byte becomes the last byte written.
            w_wr   = 1'b1;
            w_del  = 1'b1;
            w_done = 1'b1;
            w_drop = 1'b1;
          end else begin
            w_wr        = r_hold_valid;
            w_byte_done = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: nibble packing and one-byte hold
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_nib_phase  <= 1'b0;
      r_low        <= 4'h0;
      r_hold       <= 8'h00;
      r_hold_valid <= 1'b0;
      r_byte_cnt   <= '0;
    end else begin
      r_nib_phase <= (r_state == S_DATA && w_state_nxt == S_DATA) ? ~r_nib_phase : 1'b0;
      if (r_state == S_DATA && !r_nib_phase) begin
        r_low <= mii_rxd;
      end
      if (w_byte_done) begin
        r_hold       <= {mii_rxd, r_low};
        r_hold_valid <= 1'b1;
        r_byte_cnt   <= r_byte_cnt + 1'b1;
      end else if (w_state_nxt != S_DATA) begin
        r_hold_valid <= 1'b0;
        r_byte_cnt   <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs and statistics
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      fifo_din       <= 8'h00;
      fifo_del       <= 1'b0;
      fifo_wren      <= 1'b0;
      frame_done     <= 1'b0;
      frame_drop     <= 1'b0;
      stat_frame_cnt <= '0;
      stat_drop_cnt  <= '0;
      stat_ovf       <= 1'b0;
    end else begin
      fifo_wren  <= w_wr_ok;
      fifo_del   <= w_wr_ok & w_del;
      fifo_din   <= w_wr_ok ? r_hold : 8'h00;
      frame_done <= w_done;
      frame_drop <= w_drop;
      if (w_wr && fifo_full) begin
        stat_ovf <= 1'b1;
      end
      if (w_done && stat_frame_cnt != {CNT_W{1'b1}}) begin
        stat_frame_cnt <= stat_frame_cnt + 1'b1;
      end
      if (w_drop && stat_drop_cnt != {CNT_W{1'b1}}) begin
        stat_drop_cnt <= stat_drop_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mii_rx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mii_rx_framer
// Purpose  : Directed self-checking bench for mii_rx_framer. Frames are sent
//            as nibble streams; a monitor logs every FIFO write and pulse, and
//            the directed steps compare the log against hand-derived values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mii_rx_framer;

  logic        clk;
  logic        arst_n;
  logic [3:0]  mii_rxd;
  logic        mii_rx_dv;
  logic        mii_rx_er;
  logic [7:0]  fifo_din;
  logic        fifo_del;
  logic        fifo_wren;
  logic        fifo_full;
  logic        fifo_afull;
  logic        frame_done;
  logic        frame_drop;
  logic [15:0] stat_frame_cnt;
  logic [15:0] stat_drop_cnt;
  logic        stat_ovf;

  int tests = 0;
  int fails = 0;

  mii_rx_framer #(.MAX_LEN(1522), .CNT_W(16)) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .mii_rxd        (mii_rxd),
    .mii_rx_dv      (mii_rx_dv),
    .mii_rx_er      (mii_rx_er),
    .fifo_din       (fifo_din),
    .fifo_del       (fifo_del),
    .fifo_wren      (fifo_wren),
    .fifo_full      (fifo_full),
    .fifo_afull     (fifo_afull),
    .frame_done     (frame_done),
    .frame_drop     (frame_drop),
    .stat_frame_cnt (stat_frame_cnt),
    .stat_drop_cnt  (stat_drop_cnt),
    .stat_ovf       (stat_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write/pulse log, sampled on the falling edge.
  logic [7:0] q_din[$];
  logic       q_del[$];
  int         n_done = 0;
  int         n_drop = 0;

  always @(negedge clk) begin
    if (arst_n) begin
      if (fifo_wren) begin
        q_din.push_back(fifo_din);
        q_del.push_back(fifo_del);
      end
      if (frame_done) n_done++;
      if (frame_drop) n_drop++;
    end
  end

  function automatic logic [7:0] byte_of(input int i);
    int t;
    t = i * 37 + 11;
    return t[7:0];
  endfunction

  // Mismatching entries among n logged writes from base; del expected on last only.
  function automatic int bad_bytes(input int base, input int n);
    int bad;
    bad = 0;
    if (q_din.size() < base + n) return n;
    for (int k = 0; k < n; k++) begin
      if (q_din[base+k] !== byte_of(k + 1) || q_del[base+k] !== (k == n - 1)) bad++;
    end
    return bad;
  endfunction

  function automatic int dels_from(input int base);
    int c;
    c = 0;
    for (int k = base; k < q_del.size(); k++) if (q_del[k] === 1'b1) c++;
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] d, input logic dv, input logic er);
    @(posedge clk);
    #1;
    mii_rxd   = d;
    mii_rx_dv = dv;
    mii_rx_er = er;
  endtask

  // Preamble (15 x 5) + SFD nibble, nbytes data bytes, optional dribble
  // nibble, then idle cycles. stop_at>0 leaves dv high after that many bytes.
  task automatic send_frame(input int nbytes, input int er_at, input bit dribble,
                            input int idle_after, input int stop_at);
    logic [7:0] b;
    for (int i = 0; i < 15; i++) drive(4'h5, 1'b1, 1'b0);
    drive(4'hD, 1'b1, 1'b0);
    for (int i = 1; i <= nbytes; i++) begin
      if (stop_at > 0 && i > stop_at) return;
      b = byte_of(i);
      drive(b[3:0], 1'b1, (i == er_at));
      drive(b[7:4], 1'b1, 1'b0);
    end
    if (dribble) drive(4'hA, 1'b1, 1'b0);
    for (int i = 0; i < idle_after; i++) drive(4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int b, d0, r0;
    arst_n     = 1'b0;
    mii_rxd    = 4'h0;
    mii_rx_dv  = 1'b0;
    mii_rx_er  = 1'b0;
    fifo_full  = 1'b0;
    fifo_afull = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", {23'd0, fifo_wren, fifo_del, fifo_din, frame_done, frame_drop}, 32'd0);
    check("reset_stats", {stat_frame_cnt, stat_drop_cnt}, 32'd0);
    check("reset_ovf", {31'd0, stat_ovf}, 32'd0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    drive(4'h0, 1'b0, 1'b0);

    // 64-byte frame
    b = q_din.size(); d0 = n_done; r0 = n_drop;
    send_frame(64, 0, 1'b0, 4, 0);
    check("f64_writes", q_din.size() - b, 64);
    check("f64_data_del", bad_bytes(b, 64), 0);
    check("f64_done", n_done - d0, 1);
    check("f64_drop", n_drop - r0, 0);
    check("f64_frame_cnt", stat_frame_cnt, 1);
    check("f64_ovf", stat_ovf, 0);

    // afull at SFD: frame dropped, following frame accepted
    b = q_din.size(); r0 = n_drop;
    fifo_afull = 1'b1;
    send_frame(64, 0, 1'b0, 4, 0);
    fifo_afull = 1'b0;
    check("afull_writes", q_din.size() - b, 0);
    check("afull_drop", n_drop - r0, 1);
    check("afull_drop_cnt", stat_drop_cnt, 1);
    b = q_din.size();
    send_frame(64, 0, 1'b0, 4, 0);
    check("after_afull_writes", q_din.size() - b, 64);
    check("after_afull_frame_cnt", stat_frame_cnt, 2);

    // rx_er on byte 20
    b = q_din.size(); d0 = n_done; r0 = n_drop;
    send_frame(64, 20, 1'b0, 4, 0);
    check("er_writes", q_din.size() - b, 19);
    check("er_data_del", bad_bytes(b, 19), 0);
    check("er_done", n_done - d0, 1);
    check("er_drop", n_drop - r0, 1);
    check("er_stats", {stat_frame_cnt, stat_drop_cnt}, {16'd3, 16'd2});

    // 1600-byte frame truncated at 1522
    b = q_din.size(); d0 = n_done; r0 = n_drop;
    send_frame(1600, 0, 1'b0, 4, 0);
    check("long_writes", q_din.size() - b, 1522);
    check("long_data_del", bad_bytes(b, 1522), 0);
    check("long_done", n_done - d0, 1);
    check("long_drop", n_drop - r0, 1);
    check("long_stats", {stat_frame_cnt, stat_drop_cnt}, {16'd4, 16'd3});

    // 64 bytes plus a dribble nibble
    b = q_din.size(); r0 = n_drop;
    send_frame(64, 0, 1'b1, 4, 0);
    check("odd_writes", q_din.size() - b, 64);
    check("odd_data_del", bad_bytes(b, 64), 0);
    check("odd_drop", n_drop - r0, 0);
    check("odd_frame_cnt", stat_frame_cnt, 5);

    // SFD immediately followed by end of carrier
    b = q_din.size(); d0 = n_done; r0 = n_drop;
    send_frame(0, 0, 1'b0, 4, 0);
    check("empty_writes", q_din.size() - b, 0);
    check("empty_done", n_done - d0, 0);
    check("empty_drop", n_drop - r0, 1);
    check("empty_stats", {stat_frame_cnt, stat_drop_cnt}, {16'd5, 16'd4});

    // FIFO full during a frame: writes suppressed, overflow sticky
    b = q_din.size();
    fifo_full = 1'b1;
    send_frame(10, 0, 1'b0, 4, 0);
    fifo_full = 1'b0;
    check("full_writes", q_din.size() - b, 0);
    check("full_ovf", stat_ovf, 1);

    // Frame A, one idle cycle, frame B interrupted by reset
    b = q_din.size();
    send_frame(64, 0, 1'b0, 1, 0);
    send_frame(64, 0, 1'b0, 0, 20);
    arst_n = 1'b0;
    #2;
    check("b2b_first_frame", bad_bytes(b, 64), 0);
    check("b2b_second_no_del", dels_from(b + 64), 0);
    check("midrst_outputs", {23'd0, fifo_wren, fifo_del, fifo_din, frame_done, frame_drop}, 32'd0);
    check("midrst_stats", {stat_frame_cnt, stat_drop_cnt}, 32'd0);
    check("midrst_ovf", stat_ovf, 0);
    mii_rx_dv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    drive(4'h0, 1'b0, 1'b0);

    // Frame C after reset
    b = q_din.size(); d0 = n_done;
    send_frame(64, 0, 1'b0, 4, 0);
    check("post_rst_writes", q_din.size() - b, 64);
    check("post_rst_data_del", bad_bytes(b, 64), 0);
    check("post_rst_done", n_done - d0, 1);
    check("post_rst_stats", {stat_frame_cnt, stat_drop_cnt}, {16'd1, 16'd0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
